// File: rtl/vending_core_param.sv
// Parametrised single-clock vending controller core: coin credit in quarters, a committed
// selection queue, one-per-cycle dispensing and greedy one-coin-per-cycle change.
module vending_core_param #(
    parameter int unsigned             N_ITEMS    = 4,
    parameter int unsigned             CNT_W      = 8,
    parameter int unsigned             VAL_W      = 16,
    parameter int unsigned             STOCK_W    = 4,
    parameter int unsigned             STOCK_INIT = 4,
    parameter int unsigned             MAX_SEL    = 4,
    parameter logic [N_ITEMS*8-1:0]    PRICE_Q    = {8'd12, 8'd8, 8'd6, 8'd10}
) (
    input  logic                      in_clk,
    input  logic                      in_restart_n,
    input  logic [CNT_W-1:0]          in_inserted_5,
    input  logic [CNT_W-1:0]          in_inserted_1,
    input  logic [CNT_W-1:0]          in_inserted_05,
    input  logic [CNT_W-1:0]          in_inserted_025,
    input  logic [N_ITEMS-1:0]        in_sel,
    input  logic                      in_next,
    input  logic                      in_finish,
    input  logic                      in_restock,
    output logic signed [VAL_W-1:0]   out_change,
    output logic [N_ITEMS-1:0]        out_stock,
    output logic [N_ITEMS-1:0]        out_csel,
    output logic [N_ITEMS-1:0]        out_spit,
    output logic                      out_coin_1,
    output logic                      out_coin_05,
    output logic                      out_coin_025,
    output logic                      out_short,
    output logic                      out_qfull,
    output logic [1:0]                out_state
);

    localparam int unsigned IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int unsigned PTR_W   = (MAX_SEL > 1) ? $clog2(MAX_SEL) : 1;
    localparam int unsigned QCNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W   = VAL_W + CNT_W + 8;
    localparam logic signed [SUM_W-1:0] VAL_MAX = (SUM_W'(1) << (VAL_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] VAL_MIN = -VAL_MAX - SUM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SELECT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic signed [VAL_W-1:0]   credit_q, credit_d;
    logic [N_ITEMS-1:0]        csel_q, csel_d;
    logic [STOCK_W-1:0]        stock_q [N_ITEMS];
    logic [STOCK_W-1:0]        stock_d [N_ITEMS];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [QCNT_W-1:0]         qcnt_q, qcnt_d;
    logic [IDX_W-1:0]          q_mem [MAX_SEL];
    logic [N_ITEMS-1:0]        stock_flags_q, stock_flags_d;
    logic                      qfull_q, qfull_d;
    logic [N_ITEMS-1:0]        spit_q, spit_d;
    logic                      coin_1_q, coin_1_d, coin_05_q, coin_05_d, coin_025_q, coin_025_d;
    logic                      short_q, short_d;

    logic                      push;
    logic [IDX_W-1:0]          push_idx;
    logic signed [SUM_W-1:0]   acc;
    logic signed [SUM_W-1:0]   coin_sum;
    logic [IDX_W-1:0]          cidx, sidx;
    logic                      sel_onehot, sel_ok;

    function automatic logic [IDX_W-1:0] idx_of(input logic [N_ITEMS-1:0] oh);
        idx_of = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (oh[i]) idx_of = IDX_W'(i);
        end
    endfunction

    function automatic logic [7:0] price_of(input logic [IDX_W-1:0] idx);
        price_of = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (idx == IDX_W'(i)) price_of = PRICE_Q[8*i +: 8];
        end
    endfunction

    function automatic logic signed [VAL_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > VAL_MAX)      sat = VAL_W'(VAL_MAX);
        else if (v < VAL_MIN) sat = VAL_W'(VAL_MIN);
        else                  sat = VAL_W'(v);
    endfunction

    // Coin value of this cycle in quarter units
    assign coin_sum = SUM_W'(in_inserted_5) * SUM_W'(20) + SUM_W'(in_inserted_1) * SUM_W'(4)
                    + SUM_W'(in_inserted_05) * SUM_W'(2) + SUM_W'(in_inserted_025);
    assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - N_ITEMS'(1))) == '0);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        csel_d     = csel_q;
        stock_d    = stock_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        qcnt_d     = qcnt_q;
        spit_d     = '0;
        coin_1_d   = 1'b0;
        coin_05_d  = 1'b0;
        coin_025_d = 1'b0;
        short_d    = 1'b0;
        push       = 1'b0;
        push_idx   = '0;
        acc        = SUM_W'(credit_q);
        cidx       = idx_of(csel_q);
        sidx       = idx_of(in_sel);
        sel_ok     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_restock) begin
                    for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
                end
                sel_ok = sel_onehot && (stock_d[sidx] != '0);
                if (coin_sum != '0 || sel_ok) begin
                    state_d  = S_SELECT;
                    credit_d = sat(acc + coin_sum);
                    if (sel_ok) csel_d = in_sel;
                end
            end
            S_SELECT: begin
                // Commit, then coins, then new selection, then finish
                if (in_next && csel_q != '0 && stock_q[cidx] != '0
                    && qcnt_q != QCNT_W'(MAX_SEL)) begin
                    push          = 1'b1;
                    push_idx      = cidx;
                    stock_d[cidx] = stock_q[cidx] - STOCK_W'(1);
                    acc           = acc - SUM_W'(price_of(cidx));
                    csel_d        = '0;
                    wr_ptr_d      = wr_ptr_q + PTR_W'(1);
                    qcnt_d        = qcnt_q + QCNT_W'(1);
                end
                credit_d = sat(acc + coin_sum);
                sel_ok   = sel_onehot && (stock_d[sidx] != '0);
                if (sel_ok) csel_d = in_sel;
                if (in_finish) begin
                    if (!credit_d[VAL_W-1]) begin
                        csel_d  = '0;
                        state_d = (qcnt_d != '0) ? S_DISPENSE : S_CHANGE;
                    end else begin
                        short_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                if (qcnt_q != '0) begin
                    spit_d   = N_ITEMS'(1) << q_mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    qcnt_d   = qcnt_q - QCNT_W'(1);
                    if (qcnt_q == QCNT_W'(1)) state_d = S_CHANGE;
                end else begin
                    state_d = S_CHANGE;
                end
            end
            default: begin
                // Greedy change; credit is never negative on entry
                if (credit_q == '0 || credit_q[VAL_W-1]) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else if (credit_q >= VAL_W'(4)) begin
                    coin_1_d = 1'b1;
                    credit_d = credit_q - VAL_W'(4);
                end else if (credit_q >= VAL_W'(2)) begin
                    coin_05_d = 1'b1;
                    credit_d  = credit_q - VAL_W'(2);
                end else begin
                    coin_025_d = 1'b1;
                    credit_d   = credit_q - VAL_W'(1);
                end
            end
        endcase

        for (int i = 0; i < N_ITEMS; i++) stock_flags_d[i] = (stock_d[i] != '0);
        qfull_d = (qcnt_d == QCNT_W'(MAX_SEL));
    end

    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            csel_q        <= '0;
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            qcnt_q        <= '0;
            stock_flags_q <= {N_ITEMS{STOCK_INIT != 0}};
            qfull_q       <= 1'b0;
            spit_q        <= '0;
            coin_1_q      <= 1'b0;
            coin_05_q     <= 1'b0;
            coin_025_q    <= 1'b0;
            short_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            csel_q        <= csel_d;
            stock_q       <= stock_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            qcnt_q        <= qcnt_d;
            stock_flags_q <= stock_flags_d;
            qfull_q       <= qfull_d;
            spit_q        <= spit_d;
            coin_1_q      <= coin_1_d;
            coin_05_q     <= coin_05_d;
            coin_025_q    <= coin_025_d;
            short_q       <= short_d;
        end
    end

    // Queue payload needs no reset: entries are only read below the count
    always_ff @(posedge in_clk) begin
        if (push) q_mem[wr_ptr_q] <= push_idx;
    end

    assign out_change   = credit_q;
    assign out_stock    = stock_flags_q;
    assign out_csel     = csel_q;
    assign out_spit     = spit_q;
    assign out_coin_1   = coin_1_q;
    assign out_coin_05  = coin_05_q;
    assign out_coin_025 = coin_025_q;
    assign out_short    = short_q;
    assign out_qfull    = qfull_q;
    assign out_state    = state_q;

endmodule

// File: tb/tb_vending_core_param.sv
// Directed bench for vending_core_param at default parameters.
module tb_vending_core_param;

    logic               in_clk;
    logic               in_restart_n;
    logic [7:0]         n5, n1, n05, n025;
    logic [3:0]         sel;
    logic               nxt, fin, rstk;
    logic signed [15:0] change;
    logic [3:0]         stock, csel, spit;
    logic               c1, c05, c025, shrt, qfull;
    logic [1:0]         st;

    int n_checks = 0;
    int n_pass   = 0;
    int spit_cnt [4];
    int c1_cnt, c05_cnt, c025_cnt;
    int first_spit, last_spit;

    vending_core_param dut (
        .in_clk          (in_clk),
        .in_restart_n    (in_restart_n),
        .in_inserted_5   (n5),
        .in_inserted_1   (n1),
        .in_inserted_05  (n05),
        .in_inserted_025 (n025),
        .in_sel          (sel),
        .in_next         (nxt),
        .in_finish       (fin),
        .in_restock      (rstk),
        .out_change      (change),
        .out_stock       (stock),
        .out_csel        (csel),
        .out_spit        (spit),
        .out_coin_1      (c1),
        .out_coin_05     (c05),
        .out_coin_025    (c025),
        .out_short       (shrt),
        .out_qfull       (qfull),
        .out_state       (st)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_in();
        n5 = '0; n1 = '0; n05 = '0; n025 = '0;
        sel = '0; nxt = 1'b0; fin = 1'b0; rstk = 1'b0;
    endtask

    // One clock with the currently driven inputs; outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge in_clk);
        #1;
        clear_in();
    endtask

    // Run DISPENSE/CHANGE to IDLE, tallying pulses
    task automatic drain();
        for (int k = 0; k < 4; k++) spit_cnt[k] = 0;
        c1_cnt = 0; c05_cnt = 0; c025_cnt = 0;
        first_spit = -1; last_spit = -1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            for (int k = 0; k < 4; k++) if (spit[k]) spit_cnt[k]++;
            if (spit != '0) begin
                if (first_spit < 0) first_spit = i;
                last_spit = i;
            end
            if (c1)   c1_cnt++;
            if (c05)  c05_cnt++;
            if (c025) c025_cnt++;
            if (st == 2'd0) break;
        end
        check("drain_idle", int'(st), 0);
    endtask

    initial begin
        clear_in();
        in_restart_n = 1'b0;
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        in_restart_n = 1'b1;
        check("rst_state", int'(st), 0);
        check("rst_change", int'(change), 0);
        check("rst_csel", int'(csel), 0);
        check("rst_stock", int'(stock), 15);
        check("rst_qfull", int'(qfull), 0);
        check("rst_spit", int'(spit), 0);
        @(posedge in_clk);
        #1;

        // 1: item A paid exactly
        sel = 4'b0001; cyc();
        check("t1_state", int'(st), 1);
        check("t1_csel", int'(csel), 1);
        n1 = 8'd1; n05 = 8'd1; cyc();
        n1 = 8'd1; cyc();
        check("t1_credit", int'(change), 10);
        nxt = 1'b1; cyc();
        check("t1_commit", int'(change), 0);
        check("t1_csel_clr", int'(csel), 0);
        fin = 1'b1; cyc();
        check("t1_disp", int'(st), 2);
        drain();
        check("t1_spit0", spit_cnt[0], 1);
        check("t1_coins", c1_cnt + c05_cnt + c025_cnt, 0);

        // 2: item C with a $5 coin
        sel = 4'b0100; n5 = 8'd1; cyc();
        check("t2_credit", int'(change), 20);
        nxt = 1'b1; cyc();
        check("t2_commit", int'(change), 12);
        fin = 1'b1; cyc();
        drain();
        check("t2_spit2", spit_cnt[2], 1);
        check("t2_coin1", c1_cnt, 3);
        check("t2_small", c05_cnt + c025_cnt, 0);
        check("t2_change", int'(change), 0);

        // 3: refund 7 quarters, greedy order
        n1 = 8'd1; n05 = 8'd1; n025 = 8'd1; cyc();
        check("t3_credit", int'(change), 7);
        sel = 4'b0011; cyc();
        check("t3_multihot", int'(csel), 0);
        fin = 1'b1; cyc();
        check("t3_change_st", int'(st), 3);
        cyc();
        check("t3_c1", int'({c1, c05, c025}), 4);
        check("t3_rem3", int'(change), 3);
        cyc();
        check("t3_c05", int'({c1, c05, c025}), 2);
        cyc();
        check("t3_c025", int'({c1, c05, c025}), 1);
        check("t3_zero", int'(change), 0);
        cyc();
        check("t3_idle", int'(st), 0);
        check("t3_nopulse", int'({c1, c05, c025}), 0);

        // 4: short finish then top up
        sel = 4'b1000; cyc();
        nxt = 1'b1; cyc();
        check("t4_neg", int'(change), -12);
        fin = 1'b1; cyc();
        check("t4_short", int'(shrt), 1);
        check("t4_stay", int'(st), 1);
        cyc();
        check("t4_short_clr", int'(shrt), 0);
        n5 = 8'd1; cyc();
        check("t4_topup", int'(change), 8);
        fin = 1'b1; cyc();
        drain();
        check("t4_spit3", spit_cnt[3], 1);
        check("t4_coin1", c1_cnt, 2);

        // 5: fill the queue with A
        rstk = 1'b1; cyc();
        check("t5_restock_idle", int'(st), 0);
        sel = 4'b0001; n5 = 8'd2; cyc();
        check("t5_credit", int'(change), 40);
        for (int i = 0; i < 3; i++) begin
            nxt = 1'b1; sel = 4'b0001; cyc();
        end
        check("t5_csel3", int'(csel), 1);
        check("t5_qfull3", int'(qfull), 0);
        nxt = 1'b1; cyc();
        check("t5_stock", int'(stock), 14);
        check("t5_qfull", int'(qfull), 1);
        check("t5_change", int'(change), 0);
        sel = 4'b0001; cyc();
        check("t5_sel_oos", int'(csel), 0);
        sel = 4'b0010; cyc();
        check("t5_sel_b", int'(csel), 2);
        nxt = 1'b1; cyc();
        check("t5_full_ign", int'(change), 0);
        check("t5_full_csel", int'(csel), 2);
        fin = 1'b1; cyc();
        drain();
        check("t5_spit0", spit_cnt[0], 4);
        check("t5_b2b", last_spit - first_spit, 3);
        check("t5_spit1", spit_cnt[1], 0);

        // 6: saturation, then reset mid-CHANGE
        for (int i = 0; i < 5; i++) begin
            n5 = 8'd255; n1 = 8'd255; n05 = 8'd255; n025 = 8'd255; cyc();
        end
        check("t6_sat", int'(change), 32767);
        n5 = 8'd255; n1 = 8'd255; n05 = 8'd255; n025 = 8'd255; cyc();
        check("t6_sat_hold", int'(change), 32767);
        fin = 1'b1; cyc();
        check("t6_change_st", int'(st), 3);
        cyc();
        check("t6_coin1", int'(c1), 1);
        check("t6_rem", int'(change), 32763);
        #2 in_restart_n = 1'b0;
        #1;
        check("t6_rst_change", int'(change), 0);
        check("t6_rst_state", int'(st), 0);
        check("t6_rst_coin", int'(c1), 0);
        @(negedge in_clk);
        in_restart_n = 1'b1;
        @(posedge in_clk);
        #1;
        check("t6_stock", int'(stock), 15);
        check("t6_state", int'(st), 0);
        check("t6_spit", int'(spit), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
